// File: rtl/rs_alu_issue_ctrl.sv
// Control core for the 16-entry ALU reservation station: busy vector, operand wakeup,
// round-robin issue selection under valid/ready, and branch kill/clear of speculative entries.
module rs_alu_issue_ctrl #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4,
   parameter int PTAG_W  = 6,
   parameter int SPEC_W  = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we1,
   input  logic [IDX_W-1:0]   waddr1,
   input  logic [PTAG_W-1:0]  tag1a,
   input  logic [PTAG_W-1:0]  tag1b,
   input  logic               rdy1a,
   input  logic               rdy1b,
   input  logic [SPEC_W-1:0]  spec1,
   input  logic               we2,
   input  logic [IDX_W-1:0]   waddr2,
   input  logic [PTAG_W-1:0]  tag2a,
   input  logic [PTAG_W-1:0]  tag2b,
   input  logic               rdy2a,
   input  logic               rdy2b,
   input  logic [SPEC_W-1:0]  spec2,
   input  logic               wk1_valid,
   input  logic [PTAG_W-1:0]  wk1_tag,
   input  logic               wk2_valid,
   input  logic [PTAG_W-1:0]  wk2_tag,
   input  logic               issue_ready,
   output logic               issue_valid,
   output logic [IDX_W-1:0]   issue_idx,
   output logic [SPEC_W-1:0]  issue_spec,
   output logic [ENTRIES-1:0] busy,
   output logic [IDX_W:0]     free_cnt,
   input  logic               kill_valid,
   input  logic [SPEC_W-1:0]  kill_mask,
   input  logic               clr_valid,
   input  logic [SPEC_W-1:0]  clr_mask
);

   // Handshake: an issue is held on issue_idx/issue_spec while issue_valid is high and
   // completes at the rising edge where issue_valid & issue_ready are both high.

   logic [ENTRIES-1:0] busy_q, rdy_a_q, rdy_b_q;
   logic [PTAG_W-1:0]  tag_a_q [ENTRIES];
   logic [PTAG_W-1:0]  tag_b_q [ENTRIES];
   logic [SPEC_W-1:0]  spec_q  [ENTRIES];
   logic [IDX_W-1:0]   rr_ptr_q;
   logic               issue_valid_q;
   logic [IDX_W-1:0]   issue_idx_q;
   logic [SPEC_W-1:0]  issue_spec_q;
   logic [IDX_W:0]     free_cnt_q;

   logic [SPEC_W-1:0]  kill_eff, clr_eff;
   logic [ENTRIES-1:0] elig, busy_n;
   logic               held_kill, advance, found, do_sel, w1_ok, w2_ok;
   logic [IDX_W-1:0]   scan, sel_idx;
   logic [IDX_W:0]     cnt_n;

   function automatic logic wake(input logic [PTAG_W-1:0] t);
      return (wk1_valid && (wk1_tag == t)) || (wk2_valid && (wk2_tag == t));
   endfunction

   always_comb begin
      kill_eff  = kill_valid ? kill_mask : '0;
      clr_eff   = clr_valid ? clr_mask : '0;
      held_kill = issue_valid_q && (|(issue_spec_q & kill_eff));
      advance   = !issue_valid_q || issue_ready || held_kill;
      w1_ok     = we1 && !(|(spec1 & kill_eff));
      w2_ok     = we2 && !(|(spec2 & kill_eff));
      elig      = '0;
      for (int i = 0; i < ENTRIES; i++)
         elig[i] = busy_q[i] & rdy_a_q[i] & rdy_b_q[i] & ~(|(spec_q[i] & kill_eff));
      // Scan upward from rr_ptr with wrap; first eligible index wins.
      found   = 1'b0;
      sel_idx = '0;
      scan    = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         scan = rr_ptr_q + IDX_W'(i);
         if (!found && elig[scan]) begin
            found   = 1'b1;
            sel_idx = scan;
         end
      end
      do_sel = advance && found;
   end

   always_comb begin
      busy_n = busy_q;
      for (int i = 0; i < ENTRIES; i++)
         if (|(spec_q[i] & kill_eff)) busy_n[i] = 1'b0;
      if (do_sel) busy_n[sel_idx] = 1'b0;
      if (w1_ok) busy_n[waddr1] = 1'b1;
      if (w2_ok) busy_n[waddr2] = 1'b1;
      cnt_n = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (!busy_n[i]) cnt_n = cnt_n + (IDX_W+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q        <= '0;
         rdy_a_q       <= '0;
         rdy_b_q       <= '0;
         rr_ptr_q      <= '0;
         issue_valid_q <= 1'b0;
         issue_idx_q   <= '0;
         issue_spec_q  <= '0;
         free_cnt_q    <= (IDX_W+1)'(ENTRIES);
         for (int i = 0; i < ENTRIES; i++) begin
            tag_a_q[i] <= '0;
            tag_b_q[i] <= '0;
            spec_q[i]  <= '0;
         end
      end else begin
         busy_q     <= busy_n;
         free_cnt_q <= cnt_n;
         for (int i = 0; i < ENTRIES; i++) begin
            if (busy_q[i] && wake(tag_a_q[i])) rdy_a_q[i] <= 1'b1;
            if (busy_q[i] && wake(tag_b_q[i])) rdy_b_q[i] <= 1'b1;
            spec_q[i] <= spec_q[i] & ~clr_eff;
         end
         // Writes land after the wakeup loop so their fields override stale entry state.
         if (w1_ok) begin
            tag_a_q[waddr1] <= tag1a;
            tag_b_q[waddr1] <= tag1b;
            rdy_a_q[waddr1] <= rdy1a | wake(tag1a);
            rdy_b_q[waddr1] <= rdy1b | wake(tag1b);
            spec_q[waddr1]  <= spec1 & ~clr_eff;
         end
         if (w2_ok) begin
            tag_a_q[waddr2] <= tag2a;
            tag_b_q[waddr2] <= tag2b;
            rdy_a_q[waddr2] <= rdy2a | wake(tag2a);
            rdy_b_q[waddr2] <= rdy2b | wake(tag2b);
            spec_q[waddr2]  <= spec2 & ~clr_eff;
         end
         if (advance) begin
            issue_valid_q <= found;
            if (found) begin
               issue_idx_q  <= sel_idx;
               issue_spec_q <= spec_q[sel_idx] & ~clr_eff;
               rr_ptr_q     <= sel_idx + IDX_W'(1);
            end
         end else begin
            issue_spec_q <= issue_spec_q & ~clr_eff;
         end
      end
   end

   assign issue_valid = issue_valid_q;
   assign issue_idx   = issue_idx_q;
   assign issue_spec  = issue_spec_q;
   assign busy        = busy_q;
   assign free_cnt    = free_cnt_q;

endmodule

// File: tb/tb_rs_alu_issue_ctrl.sv
// Directed bench for rs_alu_issue_ctrl: completed issues are checked against an
// expected-index queue, other outputs against constants at each step.
module tb_rs_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        we1, we2, rdy1a, rdy1b, rdy2a, rdy2b;
   logic [3:0]  waddr1, waddr2;
   logic [5:0]  tag1a, tag1b, tag2a, tag2b, wk1_tag, wk2_tag;
   logic [4:0]  spec1, spec2, kill_mask, clr_mask;
   logic        wk1_valid, wk2_valid, issue_ready, kill_valid, clr_valid;
   logic        issue_valid;
   logic [3:0]  issue_idx;
   logic [4:0]  issue_spec;
   logic [15:0] busy;
   logic [4:0]  free_cnt;

   logic [3:0]  exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   rs_alu_issue_ctrl dut (
      .clk(clk), .reset(reset),
      .we1(we1), .waddr1(waddr1), .tag1a(tag1a), .tag1b(tag1b),
      .rdy1a(rdy1a), .rdy1b(rdy1b), .spec1(spec1),
      .we2(we2), .waddr2(waddr2), .tag2a(tag2a), .tag2b(tag2b),
      .rdy2a(rdy2a), .rdy2b(rdy2b), .spec2(spec2),
      .wk1_valid(wk1_valid), .wk1_tag(wk1_tag),
      .wk2_valid(wk2_valid), .wk2_tag(wk2_tag),
      .issue_ready(issue_ready), .issue_valid(issue_valid),
      .issue_idx(issue_idx), .issue_spec(issue_spec),
      .busy(busy), .free_cnt(free_cnt),
      .kill_valid(kill_valid), .kill_mask(kill_mask),
      .clr_valid(clr_valid), .clr_mask(clr_mask)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we1 = 0; we2 = 0; wk1_valid = 0; wk2_valid = 0;
      kill_valid = 0; clr_valid = 0; kill_mask = '0; clr_mask = '0;
   endtask

   task automatic wr1(input logic [3:0] idx, input logic [5:0] ta, input logic [5:0] tb,
                      input logic ra, input logic rb, input logic [4:0] sp);
      we1 = 1; waddr1 = idx; tag1a = ta; tag1b = tb; rdy1a = ra; rdy1b = rb; spec1 = sp;
   endtask

   task automatic wr2(input logic [3:0] idx, input logic [5:0] ta, input logic [5:0] tb,
                      input logic ra, input logic rb, input logic [4:0] sp);
      we2 = 1; waddr2 = idx; tag2a = ta; tag2b = tb; rdy2a = ra; rdy2b = rb; spec2 = sp;
   endtask

   // scoreboard: each completed handshake pops one expected index
   always @(negedge clk) begin
      if (!reset && issue_valid && issue_ready) begin
         if (exp_q.size() == 0) check("unexpected_issue", 32'(issue_idx), 32'hdead);
         else check("issue_order", 32'(issue_idx), 32'(exp_q.pop_front()));
      end
   end

   // illegal stimulus guards
   always @(negedge clk) begin
      if (!reset) begin
         assert (!(we1 && we2 && waddr1 == waddr2)) else $error("FAIL illegal_same_addr");
         assert (!(we1 && busy[waddr1])) else $error("FAIL illegal_write_busy1");
         assert (!(we2 && busy[waddr2])) else $error("FAIL illegal_write_busy2");
         assert (!kill_valid || $onehot(kill_mask)) else $error("FAIL illegal_kill_mask");
      end
   end

   initial begin
      reset = 1; issue_ready = 0;
      waddr1 = '0; waddr2 = '0; tag1a = '0; tag1b = '0; tag2a = '0; tag2b = '0;
      rdy1a = 0; rdy1b = 0; rdy2a = 0; rdy2b = 0; spec1 = '0; spec2 = '0;
      wk1_tag = '0; wk2_tag = '0;
      idle();
      tick(); tick();
      reset = 0;
      tick();
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_free", 32'(free_cnt), 32'd16);
      check("reset_valid", 32'(issue_valid), 32'd0);
      check("reset_idx", 32'(issue_idx), 32'd0);
      check("reset_spec", 32'(issue_spec), 32'd0);

      // single ready write, issued one edge later
      issue_ready = 1;
      wr1(4'd3, 6'h01, 6'h02, 1, 1, 5'b0);
      exp_q.push_back(4'd3);
      tick(); idle();
      check("wr3_busy", 32'(busy), 32'h0008);
      check("wr3_free", 32'(free_cnt), 32'd15);
      check("wr3_not_yet", 32'(issue_valid), 32'd0);
      tick();
      check("wr3_valid", 32'(issue_valid), 32'd1);
      check("wr3_idx", 32'(issue_idx), 32'd3);
      check("wr3_busy_clr", 32'(busy), 32'h0);
      check("wr3_free_back", 32'(free_cnt), 32'd16);
      tick();
      check("wr3_drain", 32'(issue_valid), 32'd0);

      // same-cycle wakeup bypass on tag_a
      wr1(4'd5, 6'h12, 6'h13, 0, 1, 5'b0);
      wk1_valid = 1; wk1_tag = 6'h12;
      exp_q.push_back(4'd5);
      tick(); idle();
      check("byp_busy", 32'(busy), 32'h0020);
      check("byp_not_yet", 32'(issue_valid), 32'd0);
      tick();
      check("byp_idx", 32'(issue_idx), 32'd5);
      tick();

      // later wakeup on tag_a
      wr1(4'd5, 6'h12, 6'h13, 0, 1, 5'b0);
      tick(); idle();
      tick();
      check("wk_waiting", 32'(issue_valid), 32'd0);
      wk1_valid = 1; wk1_tag = 6'h12;
      exp_q.push_back(4'd5);
      tick(); idle();
      check("wk_not_yet", 32'(issue_valid), 32'd0);
      tick();
      check("wk_valid", 32'(issue_valid), 32'd1);
      check("wk_idx", 32'(issue_idx), 32'd5);
      tick();

      // both CDB ports hit one entry in the same cycle
      wr1(4'd10, 6'h21, 6'h22, 0, 0, 5'b0);
      tick(); idle();
      wk1_valid = 1; wk1_tag = 6'h21; wk2_valid = 1; wk2_tag = 6'h22;
      exp_q.push_back(4'd10);
      tick(); idle();
      tick();
      check("wk2_idx", 32'(issue_idx), 32'd10);
      tick();

      // issue entry 7 so rr_ptr lands on 8
      wr1(4'd7, 6'h01, 6'h01, 1, 1, 5'b0);
      exp_q.push_back(4'd7);
      tick(); idle();
      tick(); tick();

      // round robin from 8: 14, 2, 7
      wr1(4'd2, 6'h01, 6'h01, 1, 1, 5'b0);
      wr2(4'd14, 6'h01, 6'h01, 1, 1, 5'b0);
      exp_q.push_back(4'd14); exp_q.push_back(4'd2); exp_q.push_back(4'd7);
      tick(); idle();
      wr1(4'd7, 6'h01, 6'h01, 1, 1, 5'b0);
      tick(); idle();
      check("rr_first", 32'(issue_idx), 32'd14);
      tick();
      check("rr_second", 32'(issue_idx), 32'd2);
      tick();
      check("rr_third", 32'(issue_idx), 32'd7);
      tick();
      check("rr_drain", 32'(issue_valid), 32'd0);

      // hold entry 9 with issue_ready low; rr_ptr=8 picks 9 before 3
      issue_ready = 0;
      wr1(4'd9, 6'h01, 6'h01, 1, 1, 5'b0);
      wr2(4'd3, 6'h01, 6'h01, 1, 1, 5'b0);
      exp_q.push_back(4'd9); exp_q.push_back(4'd3);
      tick(); idle();
      for (int k = 0; k < 3; k++) begin
         tick();
         check("hold_idx", 32'(issue_idx), 32'd9);
         check("hold_busy", 32'(busy), 32'h0008);
      end
      issue_ready = 1;
      tick();
      check("hold_next", 32'(issue_idx), 32'd3);
      tick();

      // kill spec bit 1 with a same-cycle speculative write
      wr1(4'd1, 6'h3a, 6'h3b, 0, 0, 5'b00010);
      wr2(4'd4, 6'h31, 6'h32, 0, 0, 5'b00001);
      tick(); idle();
      kill_valid = 1; kill_mask = 5'b00010;
      wr2(4'd6, 6'h01, 6'h01, 1, 1, 5'b00010);
      tick(); idle();
      check("kill_busy", 32'(busy), 32'h0010);
      check("kill_free", 32'(free_cnt), 32'd15);
      tick();
      check("kill_no_issue", 32'(issue_valid), 32'd0);

      // clear spec bit 0, then wake entry 4 and observe its spec
      clr_valid = 1; clr_mask = 5'b00001;
      tick(); idle();
      wk1_valid = 1; wk1_tag = 6'h31; wk2_valid = 1; wk2_tag = 6'h32;
      exp_q.push_back(4'd4);
      tick(); idle();
      tick();
      check("clr_idx", 32'(issue_idx), 32'd4);
      check("clr_spec", 32'(issue_spec), 32'd0);
      tick();

      // kill a held issue; another entry is selected on the same edge
      issue_ready = 0;
      wr1(4'd8, 6'h01, 6'h01, 1, 1, 5'b00100);
      wr2(4'd12, 6'h01, 6'h01, 1, 1, 5'b0);
      exp_q.push_back(4'd12);
      tick(); idle();
      tick();
      check("hk_idx", 32'(issue_idx), 32'd8);
      check("hk_spec", 32'(issue_spec), 32'h04);
      kill_valid = 1; kill_mask = 5'b00100;
      tick(); idle();
      check("hk_valid", 32'(issue_valid), 32'd1);
      check("hk_new_idx", 32'(issue_idx), 32'd12);
      check("hk_busy", 32'(busy), 32'h0);
      issue_ready = 1;
      tick();
      check("hk_drain", 32'(issue_valid), 32'd0);

      tick();
      check("end_free", 32'(free_cnt), 32'd16);
      check("end_queue", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
